rf_scan_reader: RTL



---
 rtl/rf_scan_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/rf_scan_reader.sv
// rf_scan_reader: walks a spare register-file read port over every index and latches
// each value for the 7-segment path. Optional live refresh under RF_SCAN_LIVE_REFRESH_EN.
module rf_scan_reader #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       sw_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic [ADDR_W-1:0] disp_idx_o,
  output logic              disp_valid_o,
  output logic              wrap_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LAT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(NUM_REGS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(READ_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_SHOW
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  dwell;
  logic [LAT_W-1:0]  wait_cnt;

  logic              hold;
  logic              scan_en;
  logic              idx_wraps;
  logic [ADDR_W-1:0] idx_next;
  logic              unused_sw;

  assign hold      = sw_i[1];
  assign scan_en   = sw_i[2];
  assign unused_sw = ^{sw_i[15:3], sw_i[0]};

  // Compare against NUM_REGS-1 rather than relying on ADDR_W overflow.
  assign idx_wraps = (idx == IDX_LAST);
  assign idx_next  = idx_wraps ? '0 : idx + ADDR_W'(1);

  // Scan sequencer: address is only written in ISSUE, so it stays put through CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      dwell        <= '0;
      wait_cnt     <= '0;
      rd_addr_o    <= '0;
      disp_data_o  <= '0;
      disp_idx_o   <= '0;
      disp_valid_o <= 1'b0;
      wrap_o       <= 1'b0;
    end else begin
      disp_valid_o <= 1'b0;
      wrap_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (scan_en && !hold) begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rd_addr_o <= idx;
          wait_cnt  <= LAT_LOAD;
          state     <= (READ_LAT == 0) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - LAT_W'(1);
          if (wait_cnt == LAT_W'(1)) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          disp_data_o  <= rd_data_i;
          disp_idx_o   <= idx;
          disp_valid_o <= 1'b1;
          dwell        <= '0;
          state        <= scan_en ? S_SHOW : S_IDLE;
        end
        S_SHOW: begin
          if (!scan_en) begin
            state <= S_IDLE;
          end else if (hold) begin
`ifdef RF_SCAN_LIVE_REFRESH_EN
            // Re-read the held index each dwell period so writes show up.
            if (dwell == DWELL_LAST) begin
              state <= S_ISSUE;
            end else begin
              dwell <= dwell + CNT_W'(1);
            end
`endif
          end else if (dwell == DWELL_LAST) begin
            idx    <= idx_next;
            wrap_o <= idx_wraps;
            state  <= S_ISSUE;
          end else begin
            dwell <= dwell + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
